// File: rtl/fsm_stim_tx.sv
// Serial stimulus transmitter / response collector for 1-bit-in, 1-bit-out FSMs.
// Shifts a word out LSB-first, captures the FSM response per bit, reports it with a one-cycle pulse.
module fsm_stim_tx #(
    parameter int   WIDTH    = 16,
    parameter int   LENW     = 5,
    parameter int   GAP      = 2,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LENW-1:0]  load_len,
    output logic             tx_bit,
    output logic             tx_en,
    input  logic             resp_in,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_valid,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    localparam logic [LENW-1:0] WIDTH_L  = LENW'(WIDTH);
    localparam logic [3:0]      GAP_LAST = 4'(GAP - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LENW-1:0]  len_q, len_d;
    logic [LENW-1:0]  idx_q, idx_d;
    logic [3:0]       gap_q, gap_d;
    logic             tx_bit_q, tx_bit_d;
    logic             tx_en_q, tx_en_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] resp_q, resp_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [LENW-1:0]  len_eff;

    // A length of zero or anything beyond the word width means a full word.
    assign len_eff = (load_len == '0 || load_len > WIDTH_L) ? WIDTH_L : load_len;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        len_d    = len_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        tx_bit_d = tx_bit_q;
        tx_en_d  = tx_en_q;
        resp_d   = resp_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load_valid) begin
                    data_d   = load_data;
                    len_d    = len_eff;
                    idx_d    = '0;
                    resp_d   = '0;
                    tx_bit_d = load_data[0];
                    tx_en_d  = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // resp_in is sampled at the end of the bit's cycle so Mealy outputs are caught.
                resp_d = resp_q | (WIDTH'(resp_in) << idx_q);
                if (idx_q != len_q - LENW'(1)) begin
                    idx_d    = idx_q + LENW'(1);
                    data_d   = data_q >> 1;
                    tx_bit_d = data_q[1];
                end else begin
                    tx_bit_d = IDLE_BIT;
                    tx_en_d  = 1'b0;
                    gap_d    = '0;
                    state_d  = (GAP > 0) ? S_GAP : S_DONE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_DONE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        valid_d = (state_d == S_DONE);
        if (valid_d) begin
            cnt_d = cnt_q + 8'd1;
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            tx_bit_q <= IDLE_BIT;
            tx_en_q  <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            resp_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            tx_bit_q <= tx_bit_d;
            tx_en_q  <= tx_en_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            resp_q   <= resp_d;
            cnt_q    <= cnt_d;
        end
    end

    // The shift word is pure datapath; it is always reloaded before use.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign load_ready = ready_q;
    assign tx_bit     = tx_bit_q;
    assign tx_en      = tx_en_q;
    assign resp_data  = resp_q;
    assign resp_valid = valid_q;
    assign busy       = busy_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_fsm_stim_tx.sv
// Directed and randomized bench for fsm_stim_tx; the response is produced by XOR-ing tx_bit
// with a per-bit mask, so the expected word is simply (data ^ mask) over the first L bits.
module tb_fsm_stim_tx;

    localparam int W = 16;
    localparam int G = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_data;
    logic [4:0]    load_len;
    logic          tx_bit;
    logic          tx_en;
    logic          resp_in;
    logic [W-1:0]  resp_data;
    logic          resp_valid;
    logic          busy;
    logic [7:0]    frame_cnt;
    logic          resp_xor;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            exp_cnt = 0;

    always #5 clk = ~clk;

    assign resp_in = tx_bit ^ resp_xor;

    fsm_stim_tx #(.WIDTH(W), .LENW(5), .GAP(G), .IDLE_BIT(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .tx_bit     (tx_bit),
        .tx_en      (tx_en),
        .resp_in    (resp_in),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_bit"}, tx_bit, 1'b0);
        chk({tag, "_tx_en"}, tx_en, 1'b0);
        chk({tag, "_ready"}, load_ready, 1'b1);
        chk({tag, "_resp_data"}, resp_data, '0);
        chk({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_frame_cnt"}, frame_cnt, 8'd0);
    endtask

    // Called at a falling edge with the block idle; leaves the bench at the falling edge of the
    // first idle cycle after DONE so frames can be issued back to back.
    task automatic run_frame(input logic [W-1:0] d, input logic [4:0] len, input logic [W-1:0] rmask,
                             input bit hold, input int abort_at);
        int           nbits;
        logic [W-1:0] lmask;
        logic [W-1:0] exp_r;
        nbits = (len == 5'd0 || int'(len) > W) ? W : int'(len);
        lmask = (nbits == W) ? '1 : ((W'(1) << nbits) - W'(1));
        exp_r = (d ^ rmask) & lmask;
        chk("accept_ready", load_ready, 1'b1);
        chk("accept_busy", busy, 1'b0);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = len;
        @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (hold) load_data = W'($urandom);
            else      load_valid = 1'b0;
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                chk_reset_outputs("abort");
                exp_cnt    = 0;
                load_valid = 1'b0;
                resp_xor   = 1'b0;
                return;
            end
            chk("bit_tx_en", tx_en, 1'b1);
            chk("bit_tx_bit", tx_bit, d[i]);
            chk("bit_busy", busy, 1'b1);
            chk("bit_ready", load_ready, 1'b0);
            chk("bit_resp_valid", resp_valid, 1'b0);
            resp_xor = rmask[i];
        end
        for (int g = 0; g < G; g++) begin
            @(negedge clk);
            chk("gap_tx_en", tx_en, 1'b0);
            chk("gap_tx_bit", tx_bit, 1'b0);
            chk("gap_resp_valid", resp_valid, 1'b0);
            chk("gap_ready", load_ready, 1'b0);
            resp_xor = 1'($urandom);
        end
        @(negedge clk);
        exp_cnt = (exp_cnt + 1) % 256;
        chk("done_resp_valid", resp_valid, 1'b1);
        chk("done_resp_data", resp_data, exp_r);
        chk("done_frame_cnt", frame_cnt, exp_cnt);
        chk("done_ready", load_ready, 1'b0);
        chk("done_busy", busy, 1'b1);
        chk("done_tx_en", tx_en, 1'b0);
        @(negedge clk);
        chk("idle_resp_valid", resp_valid, 1'b0);
        chk("idle_resp_data", resp_data, exp_r);
        chk("idle_ready", load_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        load_valid = 1'b0;
        resp_xor   = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        resp_xor   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Loopback full word, explicit length-4 truncation, inverted loopback.
        run_frame(16'hA5C3, 5'd0, 16'h0000, 1'b0, -1);
        run_frame(16'hFFFF, 5'd4, 16'h0000, 1'b0, -1);
        run_frame(16'h00F0, 5'd8, 16'hFFFF, 1'b0, -1);

        // load_valid held high: exactly one accept per frame, next one L+GAP+2 later.
        run_frame(W'($urandom), 5'd16, 16'h0000, 1'b1, -1);
        run_frame(W'($urandom), 5'd16, W'($urandom), 1'b1, -1);

        // Reset during bit 5 of a 16-bit frame.
        run_frame(W'($urandom), 5'd0, 16'h0000, 1'b0, 5);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            chk("post_abort_resp_valid", resp_valid, 1'b0);
            chk("post_abort_busy", busy, 1'b0);
        end
        chk("post_abort_frame_cnt", frame_cnt, 8'd0);

        // Random words, lengths (including 0 and >WIDTH), response masks and hold behaviour.
        for (int n = 0; n < 24; n++) begin
            run_frame(W'($urandom), 5'($urandom_range(0, 31)), W'($urandom), 1'($urandom), -1);
        end

        // Counter wrap: 256 back-to-back single-bit frames from a fresh reset.
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        for (int n = 0; n < 256; n++) begin
            run_frame(W'($urandom), 5'd1, W'($urandom), 1'b0, -1);
            if (n == 254) chk("wrap_255", frame_cnt, 8'd255);
        end
        chk("wrap_0", frame_cnt, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
